// File: rtl/baby_kyber_decrypt.sv
// baby_kyber_decrypt: sequential w = v - s^T*u in Z_Q[x]/(x^N+1), one MAC per cycle,
// with each coefficient of w decoded to one message bit.
module baby_kyber_decrypt #(
    parameter int Q  = 17,
    parameter int N  = 4,
    parameter int K  = 2,
    parameter int CW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [K*N*CW-1:0] sk_flat,
    input  logic [K*N*CW-1:0] u_flat,
    input  logic [N*CW-1:0]   v_flat,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      msg,
    output logic              busy
);
    localparam int NW = (N > 1) ? $clog2(N) : 1;
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int QW = $clog2(Q);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t        state_q;
    logic [QW-1:0] s_q [K*N];
    logic [QW-1:0] u_q [K*N];
    logic [QW-1:0] v_q [N];
    logic [QW-1:0] w_q [N];
    logic [QW-1:0] acc_q;
    logic [NW-1:0] k_q, j_q;
    logic [KW-1:0] i_q;
    logic [N-1:0]  msg_q;

    logic [NW-1:0]   idx;
    logic [2*QW-1:0] prod;
    logic [QW-1:0]   term_m, term, acc_d, wk_d;
    logic [QW:0]     sum;
    logic            last_j, last_i, last_k;
    logic [N-1:0]    msg_d;

    function automatic logic [QW-1:0] red_u(input logic [CW-1:0] x);
        return QW'((x >= CW'(Q)) ? x - CW'(Q) : x);
    endfunction

    // Negative two's-complement keys land in [0,Q-1] by a wrapping add of Q.
    function automatic logic [QW-1:0] red_s(input logic [CW-1:0] x);
        return x[CW-1] ? QW'(x + CW'(Q)) : red_u(x);
    endfunction

    assign in_ready  = (state_q == IDLE);
    assign busy      = !in_ready;
    assign out_valid = (state_q == OUT);
    assign msg       = msg_q;

    assign last_j = (j_q == NW'(N - 1));
    assign last_i = (i_q == KW'(K - 1));
    assign last_k = (k_q == NW'(N - 1));

    // x^N = -1: a term whose index wrapped past zero is negated.
    always_comb begin
        idx    = k_q - j_q;
        prod   = (2*QW)'(s_q[{i_q, j_q}]) * (2*QW)'(u_q[{i_q, idx}]);
        term_m = QW'(prod % (2*QW)'(Q));
        term   = (j_q > k_q && term_m != '0) ? QW'(Q) - term_m : term_m;
        sum    = {1'b0, acc_q} + {1'b0, term};
        acc_d  = (sum >= (QW+1)'(Q)) ? QW'(sum - (QW+1)'(Q)) : sum[QW-1:0];
        wk_d   = (v_q[k_q] >= acc_d) ? v_q[k_q] - acc_d : QW'(Q) - acc_d + v_q[k_q];
        msg_d  = '0;
        for (int n = 0; n < N; n++) begin
            msg_d[n] = (NW'(n) == k_q) ? (4 * int'(wk_d) > Q && 4 * int'(wk_d) < 3 * Q)
                                       : (4 * int'(w_q[n]) > Q && 4 * int'(w_q[n]) < 3 * Q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            k_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            msg_q   <= '0;
            for (int n = 0; n < K*N; n++) begin
                s_q[n] <= '0;
                u_q[n] <= '0;
            end
            for (int n = 0; n < N; n++) begin
                v_q[n] <= '0;
                w_q[n] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    for (int n = 0; n < K*N; n++) begin
                        s_q[n] <= red_s(sk_flat[n*CW +: CW]);
                        u_q[n] <= red_u(u_flat[n*CW +: CW]);
                    end
                    for (int n = 0; n < N; n++) begin
                        v_q[n] <= red_u(v_flat[n*CW +: CW]);
                        w_q[n] <= '0;
                    end
                    acc_q   <= '0;
                    k_q     <= '0;
                    i_q     <= '0;
                    j_q     <= '0;
                    state_q <= MAC;
                end
                MAC: begin
                    acc_q <= (last_j && last_i) ? '0 : acc_d;
                    j_q   <= last_j ? '0 : j_q + 1'b1;
                    if (last_j)
                        i_q <= last_i ? '0 : i_q + 1'b1;
                    if (last_j && last_i) begin
                        w_q[k_q] <= wk_d;
                        k_q      <= k_q + 1'b1;
                        if (last_k) begin
                            msg_q   <= msg_d;
                            state_q <= OUT;
                        end
                    end
                end
                OUT: if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_baby_kyber_decrypt.sv
// tb_baby_kyber_decrypt: directed vectors, backpressure/reset sequences and random
// bundles checked against a polynomial-arithmetic reference model.
module tb_baby_kyber_decrypt;
    logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
    logic [39:0] sk_flat = '0, u_flat = '0;
    logic [19:0] v_flat = '0;
    logic        in_ready, out_valid, busy;
    logic [3:0]  msg;
    int          checks = 0, errors = 0;

    typedef struct {
        logic [39:0] sk;
        logic [39:0] u;
        logic [19:0] v;
        logic [3:0]  m;
    } vec_t;
    vec_t tv[5];

    always #5 clk = ~clk;

    baby_kyber_decrypt dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .sk_flat(sk_flat), .u_flat(u_flat), .v_flat(v_flat),
        .out_valid(out_valid), .out_ready(out_ready), .msg(msg), .busy(busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [39:0] p8(input int c[8]);
        logic [39:0] r;
        for (int n = 0; n < 8; n++) r[n*5 +: 5] = 5'(c[n]);
        return r;
    endfunction

    function automatic logic [19:0] p4(input int c[4]);
        logic [19:0] r;
        for (int n = 0; n < 4; n++) r[n*5 +: 5] = 5'(c[n]);
        return r;
    endfunction

    // Schoolbook product with x^4 = -1, then w = v - s.u and round(2w/17) mod 2.
    function automatic logic [3:0] model(input logic [39:0] sk, input logic [39:0] u, input logic [19:0] v);
        int s[2][4], uu[2][4], w;
        logic [4:0] c;
        logic [3:0] m;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 4; j++) begin
                c = sk[(i*4+j)*5 +: 5];
                s[i][j] = (int'($signed(c)) % 17 + 17) % 17;
                c = u[(i*4+j)*5 +: 5];
                uu[i][j] = int'(c) % 17;
            end
        for (int k = 0; k < 4; k++) begin
            c = v[k*5 +: 5];
            w = int'(c) % 17;
            for (int i = 0; i < 2; i++)
                for (int a = 0; a < 4; a++)
                    for (int b = 0; b < 4; b++)
                        if ((a + b) % 4 == k) w += ((a + b < 4) ? -1 : 1) * s[i][a] * uu[i][b];
            w = (w % 17 + 17) % 17;
            m[k] = ((4 * w + 17) / 34) % 2 == 1;
        end
        return m;
    endfunction

    task automatic send(input logic [39:0] sk, input logic [39:0] u, input logic [19:0] v);
        @(negedge clk);
        sk_flat = sk; u_flat = u; v_flat = v; in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
        chk("accept_busy", busy, 1);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready = 1;
        @(posedge clk);
        #1 out_ready = 0;
        chk("hs_in_ready", in_ready, 1);
        chk("hs_out_valid", out_valid, 0);
    endtask

    task automatic chk_reset();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_msg", msg, 0);
    endtask

    initial begin
        int lat, r;
        logic [39:0] sk, u;
        logic [19:0] v;
        logic [3:0] exp_m;
        tv[0] = '{p8('{1,0,0,0,0,0,0,0}), p8('{3,0,0,0,7,7,7,7}), p4('{12,0,9,0}), 4'b0101};
        tv[1] = '{p8('{0,1,0,0,0,0,0,0}), p8('{0,0,0,1,0,0,0,0}), p4('{8,0,0,0}), 4'b0001};
        tv[2] = '{p8('{31,0,0,0,0,0,0,0}), p8('{21,0,0,0,0,0,0,0}), p4('{1,0,0,0}), 4'b0001};
        tv[3] = '{p8('{31,0,0,0,0,0,0,0}), p8('{21,0,0,0,0,0,0,0}), p4('{0,0,0,0}), 4'b0000};
        tv[4] = '{p8('{0,0,0,0,0,0,0,0}), p8('{5,9,3,16,2,8,1,4}), p4('{4,5,12,13}), 4'b0110};
        #3 chk_reset();
        @(negedge clk) rst_n = 1;
        for (int t = 0; t < 5; t++) begin
            send(tv[t].sk, tv[t].u, tv[t].v);
            wait_out(lat);
            chk($sformatf("latency_%0d", t), lat, 32);
            chk($sformatf("msg_%0d", t), msg, tv[t].m);
            handshake();
        end
        // Backpressure with an ignored in_valid pulse while OUT holds.
        send(tv[0].sk, tv[0].u, tv[0].v);
        wait_out(lat);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_msg", msg, 4'b0101);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            if (c == 4) begin
                sk_flat = tv[4].sk; u_flat = tv[4].u; v_flat = tv[4].v; in_valid = 1;
            end
            if (c == 5) in_valid = 0;
        end
        handshake();
        repeat (3) begin
            @(negedge clk);
            chk("post_bp_out_valid", out_valid, 0);
            chk("post_bp_in_ready", in_ready, 1);
        end
        // Asynchronous reset in the middle of MAC.
        send(tv[1].sk, tv[1].u, tv[1].v);
        repeat (15) @(posedge clk);
        #2 rst_n = 0;
        #1 chk_reset();
        @(negedge clk) rst_n = 1;
        send(tv[2].sk, tv[2].u, tv[2].v);
        wait_out(lat);
        chk("after_rst_latency", lat, 32);
        chk("after_rst_msg", msg, tv[2].m);
        handshake();
        for (int b = 0; b < 1000; b++) begin
            for (int n = 0; n < 8; n++) begin
                r = $urandom_range(0, 2);
                sk[n*5 +: 5] = (r == 2) ? 5'h1f : 5'(r);
                u[n*5 +: 5] = 5'($urandom_range(0, 16));
            end
            for (int n = 0; n < 4; n++) v[n*5 +: 5] = 5'($urandom_range(0, 16));
            exp_m = model(sk, u, v);
            send(sk, u, v);
            wait_out(lat);
            chk("rand_msg", msg, exp_m);
            handshake();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/baby_kyber_decrypt.md
# baby_kyber_decrypt

Sequential Baby-Kyber decryption core, the receiving end of the key-generation and encryption path: it takes the secret key vector s (K polynomials, small signed coefficients) and a ciphertext (u, v), computes w = v − sᵀ·u in Z_Q[x]/(x^N+1), and decodes each coefficient of w to one message bit. One multiply-accumulate runs per cycle through a single shared MAC, and the block sits behind the ciphertext source with valid/ready handshakes on both sides.

## Interface
- Q, 17: modulus (odd, < 2^CW)
- N, 4: polynomial length (coefficients per polynomial)
- K, 2: module rank (polynomials per vector)
- CW, 5: input coefficient width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  ciphertext/key bundle valid
- in_ready  out  1  block idle, can accept
- sk_flat  in  K*N*CW  s; coeff j of poly i at [(i*N+j)*CW +: CW], signed two's complement
- u_flat  in  K*N*CW  u; same packing, unsigned
- v_flat  in  N*CW  v; coeff j at [j*CW +: CW], unsigned
- out_valid  out  1  msg valid
- out_ready  in  1  consumer accepts msg
- msg  out  N  decoded message, bit k = m[k]
- busy  out  1  high in MAC or OUT state

## Operation
- FSM states: IDLE, MAC, OUT. in_ready = (state==IDLE); busy = !in_ready.
- IDLE: on an edge with in_valid & in_ready, capture and reduce all inputs into internal registers (all values in [0,Q-1]), clear counters and the accumulator, and go to MAC.
- Capture reduction:
  - u, v: value ≥ Q → value − Q (a single subtraction suffices for CW=5, Q=17).
  - sk: negative → value + Q; otherwise the same single-subtract rule.
- MAC: counters k (outer, 0..N-1), i (0..K-1), j (inner, 0..N-1); one step per cycle, K*N*N = 32 steps.
  - Step: idx = (k−j) mod N; term = s_i[j]*u_i[idx]; term is negated mod Q when k−j < 0 (negacyclic wrap x^N = −1).
  - acc ← (acc + term) mod Q, kept in [0,Q-1] every step.
  - Products are at most (Q−1)^2 = 256 and need 9 bits; the reduction is exact with no truncation.
- End of k (last i, last j): w[k] ← (v[k] − acc_final) mod Q in [0,Q-1]; acc clears.
- After the last step (k=N-1, i=K-1, j=N-1):
  - msg[k] ← 1 iff round(2·w[k]/Q) mod 2 = 1, i.e. w[k] in [5,12] for Q=17.
  - Go to OUT.
- OUT: out_valid = 1. msg is held stable until out_valid & out_ready on an edge, then the FSM returns to IDLE.
- Changes to in_valid or the inputs while not in IDLE are ignored.

## Timing
- Reset (async assert): state=IDLE, in_ready=1, busy=0, out_valid=0, msg=0, acc/w/counters/captured regs = 0.
- Reset mid-MAC or mid-OUT aborts the operation. No output is produced, and the bundle must be re-sent after release.
- Acceptance edge E0 → MAC steps commit on edges E1..E32 → out_valid=1 and msg valid after E32 (latency 32 cycles from acceptance).
- out_valid stays high over any number of out_ready-low cycles.
- Handshake edge Eh with out_ready=1 → IDLE after Eh; in_ready=1 in the following cycle.
- Minimum throughput is one message per 34 cycles (accept, 32 MAC steps, out handshake). There is no overlap between out handshake and next accept.
- out_ready high before out_valid has no effect.

## Test plan
- Basic: s0=[1,0,0,0], s1=0, u0=[3,0,0,0], u1=[7,7,7,7], v=[12,0,9,0] → w=[9,0,9,0], msg=4'b0101, out_valid exactly 32 cycles after acceptance.
- Negacyclic wrap: s0=[0,1,0,0], u0=[0,0,0,1], s1=u1=0, v=[8,0,0,0] → s0·u0=[16,0,0,0], w=[9,0,0,0], msg=4'b0001.
- Signed key plus input reduction:
  - s0=[5'b11111,0,0,0] (−1), u0=[21,0,0,0] (reduces to 4), v=[1,0,0,0] → w=[5,0,0,0], msg=4'b0001.
  - Same bundle with v=[0,0,0,0] → w=[4,0,0,0], msg=0.
- Decode thresholds: s=0, v=[4,5,12,13] → msg=4'b0110.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - msg and out_valid stay stable; in_ready=0; a new in_valid pulse is ignored.
  - After out_ready=1, in_ready rises the next cycle.
- Reset mid-operation: assert rst_n=0 at MAC step 15 → all outputs go to reset values immediately. After release, a fresh bundle yields the correct msg.
- Random (in addition to the directed cases): 1000 bundles with sk in {−1,0,1} and u, v in [0,16], checked against a reference model of v − sᵀu mod (x^4+1, 17).
